// File: rtl/multicycle_controller_pkg.sv
// Shared types and encodings for the multicycle RISC-V control unit.
// Holds the FSM state enum, the opcode constants and the ALU control and alu_op codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Bit 0 of every subtracting code tells the ALU to invert src_B.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's alu_op plus the instruction
// function fields into the 3-bit ALU select.
module alu_decoder
    import multicycle_controller_pkg::*;
(
    input  logic [1:0] i_aluOp,
    input  logic [2:0] i_funct3,
    input  logic       i_op5,
    input  logic       i_funct7b5,
    output logic [2:0] o_aluControl
);

    always_comb begin
        o_aluControl = ALU_ADD;
        case (i_aluOp)
            ALUOP_ADD: o_aluControl = ALU_ADD;
            ALUOP_SUB: o_aluControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    // Only R-type (op[5] set) can subtract; addi ignores instr[30].
                    3'b000:  o_aluControl = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  o_aluControl = ALU_SLT;
                    3'b110:  o_aluControl = ALU_OR;
                    3'b111:  o_aluControl = ALU_AND;
                    default: o_aluControl = ALU_ADD;
                endcase
            end
            default: o_aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for a multicycle RISC-V datapath, with immediate-type
// decode and the ALU decoder sub-block.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic [3:0] state_o
);

    state_t     r_state;
    state_t     w_nextState;
    logic       w_pcUpdate;
    logic       w_branch;
    logic       w_memWrite;
    logic       w_irWrite;
    logic       w_regWrite;
    logic [1:0] w_aluOp;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = S_FETCH;
        w_pcUpdate  = 1'b0;
        w_branch    = 1'b0;
        w_memWrite  = 1'b0;
        w_irWrite   = 1'b0;
        w_regWrite  = 1'b0;
        w_aluOp     = ALUOP_ADD;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_irWrite   = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                w_pcUpdate  = 1'b1;
                w_nextState = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_nextState = S_MEMADR;
                    OP_RTYPE:          w_nextState = S_EXECUTER;
                    OP_ITYPE:          w_nextState = S_EXECUTEI;
                    OP_JAL:            w_nextState = S_JAL;
                    OP_BRANCH:         w_nextState = S_BEQ;
                    default:           w_nextState = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                w_nextState = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src     = 1'b1;
                w_nextState = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                w_regWrite  = 1'b1;
                w_nextState = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src     = 1'b1;
                w_memWrite  = 1'b1;
                w_nextState = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = 2'b10;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = 2'b10;
                alu_src_b   = 2'b01;
                w_aluOp     = ALUOP_FUNCT;
                w_nextState = S_ALUWB;
            end
            S_ALUWB: begin
                w_regWrite  = 1'b1;
                w_nextState = S_FETCH;
            end
            S_JAL: begin
                alu_src_a   = 2'b01;
                alu_src_b   = 2'b10;
                w_pcUpdate  = 1'b1;
                w_nextState = S_ALUWB;
            end
            S_BEQ: begin
                alu_src_a   = 2'b10;
                w_aluOp     = ALUOP_SUB;
                w_branch    = 1'b1;
                w_nextState = S_FETCH;
            end
            default: w_nextState = S_FETCH;
        endcase
    end

    // Write strobes are masked by reset so nothing is committed while held in reset.
    assign pc_write  = reset_n & (w_pcUpdate | (w_branch & zero));
    assign ir_write  = reset_n & w_irWrite;
    assign mem_write = reset_n & w_memWrite;
    assign reg_write = reset_n & w_regWrite;
    assign state_o   = r_state;

    always_comb begin
        imm_src = 2'b00;
        case (op)
            OP_ITYPE, OP_LOAD: imm_src = 2'b00;
            OP_STORE:          imm_src = 2'b01;
            OP_BRANCH:         imm_src = 2'b10;
            OP_JAL:            imm_src = 2'b11;
            default:           imm_src = 2'b00;
        endcase
    end

    alu_decoder u_aluDecoder (
        .i_aluOp      (w_aluOp),
        .i_funct3     (funct3),
        .i_op5        (op[5]),
        .i_funct7b5   (funct7b5),
        .o_aluControl (alu_control)
    );

endmodule
